// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: stall-vector/flush/bubble control (MODE 0)
// or valid/ready with a 2-entry skid buffer (MODE 1), plus a saturating bubble counter.
module pipe_stage_reg #(
    parameter int                DATA_W    = 128,
    parameter int                SIDE_W    = 1,
    parameter int                STALL_W   = 6,
    parameter int                STAGE     = 2,
    parameter int                MODE      = 0,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SIDE_W-1:0]  in_side,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [SIDE_W-1:0]  out_side,
    output logic [1:0]         occupancy,
    output logic [15:0]        bubble_cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic              r_vld_p1;
    logic [DATA_W-1:0] r_data_p1;
    logic [SIDE_W-1:0] r_side_p1;
    logic              r_skid_vld_p1;
    logic [DATA_W-1:0] r_skid_data_p1;
    logic [SIDE_W-1:0] r_skid_side_p1;
    logic [15:0]       r_bubble_cnt;

    logic w_up_stall;
    logic w_dn_stall;
    logic w_accept;
    logic w_pop;
    logic w_bubble;
    logic w_unused_stall;

    // Only the two stall bits around this stage matter; the rest are consumed here.
    assign w_unused_stall = ^stall;
    assign w_up_stall     = stall[STAGE];
    assign w_dn_stall     = stall[STAGE+1];

    // MODE 1 ready depends on registered skid state only, never on out_ready.
    assign in_ready = (MODE == 0) ? !w_up_stall : !r_skid_vld_p1;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = r_vld_p1 && out_ready;
    assign w_bubble = (MODE == 0) ? (!flush && w_up_stall && !w_dn_stall)
                                  : (!r_vld_p1 && out_ready);

    // Stage boundary: upstream -> registered output (main) and skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1       <= 1'b0;
            r_data_p1      <= NOP_VALUE;
            r_side_p1      <= '0;
            r_skid_vld_p1  <= 1'b0;
            r_skid_data_p1 <= NOP_VALUE;
            r_skid_side_p1 <= '0;
        end else if (MODE == 0) begin
            r_skid_vld_p1 <= 1'b0;
            if (flush) begin
                r_vld_p1  <= 1'b0;
                r_data_p1 <= NOP_VALUE;
                r_side_p1 <= '0;
            end else if (w_up_stall && !w_dn_stall) begin
                // Bubble keeps the sideband so a delay-slot flag survives.
                r_vld_p1  <= 1'b0;
                r_data_p1 <= NOP_VALUE;
            end else if (!w_up_stall) begin
                r_vld_p1  <= in_valid;
                r_data_p1 <= in_data;
                r_side_p1 <= in_side;
            end
        end else begin
            if (flush) begin
                r_vld_p1      <= 1'b0;
                r_data_p1     <= NOP_VALUE;
                r_side_p1     <= '0;
                r_skid_vld_p1 <= 1'b0;
            end else if (w_pop) begin
                if (r_skid_vld_p1) begin
                    r_data_p1     <= r_skid_data_p1;
                    r_side_p1     <= r_skid_side_p1;
                    r_skid_vld_p1 <= 1'b0;
                end else if (w_accept) begin
                    r_data_p1 <= in_data;
                    r_side_p1 <= in_side;
                end else begin
                    r_vld_p1 <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_vld_p1) begin
                    r_vld_p1  <= 1'b1;
                    r_data_p1 <= in_data;
                    r_side_p1 <= in_side;
                end else begin
                    r_skid_vld_p1  <= 1'b1;
                    r_skid_data_p1 <= in_data;
                    r_skid_side_p1 <= in_side;
                end
            end
        end
    end

    // Flush deliberately leaves the performance counter alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble) begin
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end
    end

    assign out_valid  = r_vld_p1;
    assign out_data   = r_data_p1;
    assign out_side   = r_side_p1;
    assign occupancy  = {1'b0, r_vld_p1} + {1'b0, r_skid_vld_p1};
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one MODE 0 and one MODE 1 instance sharing clock and reset.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic [5:0]   a_stall;
    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_in_data, a_out_data;
    logic [0:0]   a_in_side, a_out_side;
    logic [1:0]   a_occ;
    logic [15:0]  a_bub;

    logic [5:0]   b_stall;
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [127:0] b_in_data, b_out_data;
    logic [0:0]   b_in_side, b_out_side;
    logic [1:0]   b_occ;
    logic [15:0]  b_bub;

    pipe_stage_reg #(.MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .stall(a_stall), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_side(a_in_side),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_side(a_out_side),
        .occupancy(a_occ), .bubble_cnt(a_bub)
    );

    pipe_stage_reg #(.MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .stall(b_stall), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_side(b_in_side),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_side(b_out_side),
        .occupancy(b_occ), .bubble_cnt(b_bub)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_stall = '0; a_flush = 0; a_in_valid = 0; a_in_data = '0; a_in_side = '0; a_out_ready = 0;
        b_stall = '0; b_flush = 0; b_in_valid = 0; b_in_data = '0; b_in_side = '0; b_out_ready = 0;
        #12;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %0h want 0", a_out_valid); end
        checks++; if (a_out_data !== 128'h0) begin errors++; $display("FAIL rst_a_data got %0h want 0", a_out_data); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_in_ready got %0h want 1", a_in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_in_ready got %0h want 1", b_in_ready); end
        checks++; if (b_occ !== 2'd0) begin errors++; $display("FAIL rst_b_occ got %0d want 0", b_occ); end
        checks++; if (b_bub !== 16'd0) begin errors++; $display("FAIL rst_b_bub got %0d want 0", b_bub); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_m0_advance();
        a_stall = 6'b000000; a_in_valid = 1; a_in_data = 128'hA5; a_in_side = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL adv_valid got %0h want 1", a_out_valid); end
        checks++; if (a_out_data !== 128'hA5) begin errors++; $display("FAIL adv_data got %0h want a5", a_out_data); end
        checks++; if (a_out_side !== 1'b1) begin errors++; $display("FAIL adv_side got %0h want 1", a_out_side); end
        checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL adv_occ got %0d want 1", a_occ); end
    endtask

    task automatic test_m0_back_to_back();
        for (int i = 0; i < 3; i++) begin
            a_in_data = 128'h100 + 128'(i); a_in_side = 1'(i); a_in_valid = 1;
            tick();
            checks++; if (a_out_data !== 128'h100 + 128'(i)) begin errors++; $display("FAIL b2b_data%0d got %0h want %0h", i, a_out_data, 128'h100 + 128'(i)); end
        end
        a_in_valid = 0; a_in_data = 128'h55;
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %0h want 0", a_out_valid); end
    endtask

    task automatic test_m0_bubble();
        a_stall = 6'b000000; a_in_valid = 1; a_in_data = 128'hA5; a_in_side = 1'b1;
        tick();
        a_stall = 6'b000111; a_in_data = 128'hEE; a_in_side = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bub_in_ready got %0h want 0", a_in_ready); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bub_valid got %0h want 0", a_out_valid); end
        checks++; if (a_out_data !== 128'h0) begin errors++; $display("FAIL bub_data got %0h want 0", a_out_data); end
        checks++; if (a_out_side !== 1'b1) begin errors++; $display("FAIL bub_side got %0h want 1", a_out_side); end
        checks++; if (a_bub !== 16'd1) begin errors++; $display("FAIL bub_cnt got %0d want 1", a_bub); end
        a_stall = 6'b001111;
        tick();
        checks++; if (a_out_side !== 1'b1) begin errors++; $display("FAIL hold_side got %0h want 1", a_out_side); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got %0h want 0", a_out_valid); end
        checks++; if (a_bub !== 16'd1) begin errors++; $display("FAIL hold_cnt got %0d want 1", a_bub); end
    endtask

    task automatic test_m0_hold_valid();
        a_stall = 6'b000000; a_in_valid = 1; a_in_data = 128'h11; a_in_side = 1'b0;
        tick();
        a_stall = 6'b001100; a_in_data = 128'h22;
        tick(); tick();
        checks++; if (a_out_data !== 128'h11) begin errors++; $display("FAIL holdv_data got %0h want 11", a_out_data); end
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL holdv_valid got %0h want 1", a_out_valid); end
    endtask

    task automatic test_m0_flush_bubble();
        a_stall = 6'b000000; a_in_valid = 1; a_in_data = 128'h5A; a_in_side = 1'b1;
        tick();
        a_flush = 1; a_stall = 6'b000111;
        tick();
        checks++; if (a_out_side !== 1'b0) begin errors++; $display("FAIL flb_side got %0h want 0", a_out_side); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flb_valid got %0h want 0", a_out_valid); end
        checks++; if (a_out_data !== 128'h0) begin errors++; $display("FAIL flb_data got %0h want 0", a_out_data); end
        checks++; if (a_bub !== 16'd1) begin errors++; $display("FAIL flb_cnt got %0d want 1", a_bub); end
        a_flush = 0; a_stall = 6'b000000; a_in_valid = 0;
        tick();
    endtask

    task automatic test_m1_skid();
        b_out_ready = 0; b_in_valid = 1; b_in_data = 128'h1;
        tick();
        checks++; if (b_occ !== 2'd1) begin errors++; $display("FAIL skid_occ1 got %0d want 1", b_occ); end
        checks++; if (b_out_data !== 128'h1) begin errors++; $display("FAIL skid_data1 got %0h want 1", b_out_data); end
        b_in_data = 128'h2;
        tick();
        checks++; if (b_occ !== 2'd2) begin errors++; $display("FAIL skid_occ2 got %0d want 2", b_occ); end
        checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready0 got %0h want 0", b_in_ready); end
        b_in_data = 128'h3;
        tick();
        checks++; if (b_occ !== 2'd2) begin errors++; $display("FAIL skid_occ3 got %0d want 2", b_occ); end
        checks++; if (b_out_data !== 128'h1) begin errors++; $display("FAIL skid_head got %0h want 1", b_out_data); end
        b_in_valid = 0; b_out_ready = 1;
        tick();
        checks++; if (b_out_data !== 128'h2) begin errors++; $display("FAIL skid_pop2 got %0h want 2", b_out_data); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready1 got %0h want 1", b_in_ready); end
        checks++; if (b_occ !== 2'd1) begin errors++; $display("FAIL skid_occ_pop got %0d want 1", b_occ); end
        tick();
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got %0h want 0", b_out_valid); end
        checks++; if (b_bub !== 16'd0) begin errors++; $display("FAIL skid_bub0 got %0d want 0", b_bub); end
        tick();
        checks++; if (b_bub !== 16'd1) begin errors++; $display("FAIL skid_bub1 got %0d want 1", b_bub); end
    endtask

    task automatic test_m1_back_to_back();
        b_out_ready = 1; b_in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            b_in_data = 128'h10 + 128'(i);
            tick();
            checks++; if (b_out_data !== 128'h10 + 128'(i) || b_in_ready !== 1'b1 || b_occ !== 2'd1) begin
                errors++; $display("FAIL m1_b2b%0d got data %0h ready %0h occ %0d want %0h 1 1", i, b_out_data, b_in_ready, b_occ, 128'h10 + 128'(i));
            end
        end
        b_in_valid = 0;
        tick();
    endtask

    task automatic test_m1_flush();
        b_out_ready = 0; b_in_valid = 1; b_in_data = 128'hA;
        tick();
        b_in_data = 128'hB;
        tick();
        checks++; if (b_occ !== 2'd2) begin errors++; $display("FAIL mfl_full got %0d want 2", b_occ); end
        b_flush = 1; b_in_data = 128'hC;
        tick();
        checks++; if (b_occ !== 2'd0) begin errors++; $display("FAIL mfl_occ got %0d want 0", b_occ); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL mfl_valid got %0h want 0", b_out_valid); end
        checks++; if (b_out_data !== 128'h0) begin errors++; $display("FAIL mfl_data got %0h want 0", b_out_data); end
        b_flush = 0; b_in_valid = 0;
        tick();
        checks++; if (b_occ !== 2'd0) begin errors++; $display("FAIL mfl_dropped got %0d want 0", b_occ); end
    endtask

    task automatic test_reset_saturated();
        b_out_ready = 1; b_in_valid = 0;
        a_stall = 6'b000000; a_in_valid = 1; a_in_data = 128'h77; a_in_side = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        checks++; if (b_bub !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %0h want ffff", b_bub); end
        checks++; if (a_out_data !== 128'h77) begin errors++; $display("FAIL pre_rst_data got %0h want 77", a_out_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (b_bub !== 16'h0) begin errors++; $display("FAIL arst_cnt got %0h want 0", b_bub); end
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== 128'h0 || a_out_side !== 1'b0) begin
            errors++; $display("FAIL arst_out got valid %0h data %0h side %0h want 0 0 0", a_out_valid, a_out_data, a_out_side);
        end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL arst_occ got %0d want 0", a_occ); end
        #10;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_m0_advance();
        test_m0_back_to_back();
        test_m0_bubble();
        test_m0_hold_valid();
        test_m0_flush_bubble();
        test_m1_skid();
        test_m1_back_to_back();
        test_m1_flush();
        test_reset_saturated();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
